// File: rtl/field_renderer.sv
// field_renderer: playfield pixel colouring with a two-stage pipeline, plus a
// line-clear flash sequencer that blinks selected rows for a number of frames.
module field_renderer #(
    parameter int ROWS         = 20,
    parameter int COLS         = 10,
    parameter int CELL         = 24,
    parameter int ORIGIN_X     = 200,
    parameter int ORIGIN_Y     = 0,
    parameter int WALL_W       = 10,
    parameter int FLASH_FRAMES = 8,
    parameter int FLASH_PAIRS  = 3,
    parameter int GRID_EN      = 1,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic            i_Clk,
    input  logic            i_Reset,
    input  logic [9:0]      i_DrawX,
    input  logic [9:0]      i_DrawY,
    input  logic            i_frame_start,
    input  logic            i_is_shape,
    input  logic            i_is_boundary,
    output logic [RW-1:0]   o_cell_row,
    output logic [CW-1:0]   o_cell_col,
    input  logic [6:0]      i_cell_code,
    input  logic            i_clear_start,
    input  logic [ROWS-1:0] i_clear_mask,
    output logic            o_busy,
    output logic            o_clear_done,
    output logic            o_is_background,
    output logic [7:0]      o_backRed,
    output logic [7:0]      o_backGreen,
    output logic [7:0]      o_backBlue
);

    localparam int FW = $clog2(FLASH_FRAMES + 1);
    localparam int PW = $clog2(FLASH_PAIRS + 1);

    // 12-bit region bounds; the left wall test adds WALL_W to the pixel
    // instead of subtracting it from ORIGIN_X so nothing can wrap.
    localparam logic [11:0] X_LO   = 12'(ORIGIN_X);
    localparam logic [11:0] X_HI   = 12'(ORIGIN_X + COLS * CELL);
    localparam logic [11:0] X_WR   = 12'(ORIGIN_X + COLS * CELL + WALL_W);
    localparam logic [11:0] Y_LO   = 12'(ORIGIN_Y);
    localparam logic [11:0] Y_HI   = 12'(ORIGIN_Y + ROWS * CELL);
    localparam logic [11:0] WW     = 12'(WALL_W);
    localparam logic [11:0] CELL12 = 12'(CELL);

    localparam logic [23:0] C_WALL  = 24'h87CEEB;
    localparam logic [23:0] C_WHITE = 24'hFFFFFF;
    localparam logic [23:0] C_BLACK = 24'h000000;
    localparam logic [23:0] C_GRID  = 24'h404040;

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_DONE} state_t;

    state_t          r_state;
    logic [FW-1:0]   r_frm;
    logic [PW-1:0]   r_pair;
    logic [ROWS-1:0] r_mask;
    logic            r_busy;
    logic            r_done;

    logic [11:0] w_x, w_y, w_off_x, w_off_y;
    logic        w_in_y, w_field, w_wall, w_grid;

    logic          r_field1, r_wall1, r_shape1, r_bnd1, r_grid1;
    logic [RW-1:0] r_row1;

    logic        w_bg;
    logic [23:0] w_rgb;
    logic        r_bg;
    logic [23:0] r_rgb;

    assign w_x     = {2'b00, i_DrawX};
    assign w_y     = {2'b00, i_DrawY};
    assign w_off_x = w_x - X_LO;
    assign w_off_y = w_y - Y_LO;
    assign w_in_y  = (w_y >= Y_LO) && (w_y < Y_HI);
    assign w_field = w_in_y && (w_x >= X_LO) && (w_x < X_HI);
    assign w_wall  = w_in_y && ((((w_x + WW) >= X_LO) && (w_x < X_LO)) ||
                                ((w_x >= X_HI) && (w_x < X_WR)));
    assign w_grid  = ((w_off_x % CELL12) == 12'd0) || ((w_off_y % CELL12) == 12'd0);

    // Stage 0: field-memory address, parked at cell (0,0) outside the field
    always_comb begin
        o_cell_row = '0;
        o_cell_col = '0;
        if (w_field) begin
            o_cell_row = RW'(w_off_y / CELL12);
            o_cell_col = CW'(w_off_x / CELL12);
        end
    end

    // Stage 1: hold pixel attributes while the field memory answers
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_field1 <= 1'b0;
            r_wall1  <= 1'b0;
            r_shape1 <= 1'b0;
            r_bnd1   <= 1'b0;
            r_grid1  <= 1'b0;
            r_row1   <= '0;
        end else begin
            r_field1 <= w_field;
            r_wall1  <= w_wall;
            r_shape1 <= i_is_shape;
            r_bnd1   <= i_is_boundary;
            r_grid1  <= w_grid;
            r_row1   <= o_cell_row;
        end
    end

    // Stage 2 colour select: wall, then empty field pixel, then foreground
    always_comb begin
        w_bg  = 1'b0;
        w_rgb = C_WHITE;
        if (r_wall1) begin
            w_bg  = 1'b1;
            w_rgb = C_WALL;
        end else if (r_field1 && !r_shape1 && !r_bnd1) begin
            w_bg = 1'b1;
            if (r_busy && r_mask[r_row1]) begin
                // DONE lasts one cycle right after an off phase, so it shows dark
                w_rgb = (r_state == S_ON) ? C_WHITE : C_BLACK;
            end else begin
                case (i_cell_code)
                    7'd0:    w_rgb = (GRID_EN != 0 && r_grid1) ? C_GRID : C_BLACK;
                    7'd1:    w_rgb = 24'h00FFFF;
                    7'd2:    w_rgb = 24'hFFFF00;
                    7'd3:    w_rgb = 24'h800080;
                    7'd4:    w_rgb = 24'h00FF00;
                    7'd5:    w_rgb = 24'hFF0000;
                    7'd6:    w_rgb = 24'h0000FF;
                    7'd7:    w_rgb = 24'hFFA500;
                    default: w_rgb = 24'h808080;
                endcase
            end
        end
    end

    // Stage 2: registered pixel result
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_bg  <= 1'b0;
            r_rgb <= C_WHITE;
        end else begin
            r_bg  <= w_bg;
            r_rgb <= w_rgb;
        end
    end

    // Flash sequencer: FLASH_PAIRS on/off pairs of FLASH_FRAMES frames each
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state <= S_IDLE;
            r_frm   <= '0;
            r_pair  <= '0;
            r_mask  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_clear_start && (|i_clear_mask)) begin
                        r_mask  <= i_clear_mask;
                        r_frm   <= '0;
                        r_pair  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_ON;
                    end
                end
                S_ON: begin
                    if (i_frame_start) begin
                        if (r_frm == FW'(FLASH_FRAMES - 1)) begin
                            r_frm   <= '0;
                            r_state <= S_OFF;
                        end else begin
                            r_frm <= r_frm + 1'b1;
                        end
                    end
                end
                S_OFF: begin
                    if (i_frame_start) begin
                        if (r_frm == FW'(FLASH_FRAMES - 1)) begin
                            r_frm  <= '0;
                            r_pair <= r_pair + 1'b1;
                            if (r_pair == PW'(FLASH_PAIRS - 1)) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_ON;
                            end
                        end else begin
                            r_frm <= r_frm + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy          = r_busy;
    assign o_clear_done    = r_done;
    assign o_is_background = r_bg;
    assign o_backRed       = r_rgb[23:16];
    assign o_backGreen     = r_rgb[15:8];
    assign o_backBlue      = r_rgb[7:0];

endmodule

// File: tb/tb_field_renderer.sv
// Scoreboard bench for field_renderer: randomized pixels against a
// geometric reference model, plus flash-sequence and reset-abort scenarios.
module tb_field_renderer;

    localparam int ROWS = 20;
    localparam int COLS = 10;
    localparam int CELL = 24;
    localparam int OX   = 200;
    localparam int FF   = 8;
    localparam int NPF  = 48;

    logic            Clk = 1'b0;
    logic            Reset = 1'b1;
    logic [9:0]      DrawX = '0, DrawY = '0;
    logic            frame_start = 1'b0, is_shape = 1'b0, is_boundary = 1'b0;
    logic [4:0]      cell_row;
    logic [3:0]      cell_col;
    logic [6:0]      cell_code = '0;
    logic            clear_start = 1'b0;
    logic [ROWS-1:0] clear_mask = '0;
    logic            busy, clear_done, is_background;
    logic [7:0]      backRed, backGreen, backBlue;

    // second instance with the reduced parameter set
    logic [9:0]  DrawX2 = '0, DrawY2 = '0;
    logic [3:0]  cell_row2;
    logic [2:0]  cell_col2;
    logic        busy2, done2, bg2;
    logic [7:0]  r2, g2, b2;

    always #5 Clk = ~Clk;

    field_renderer dut (
        .i_Clk(Clk), .i_Reset(Reset), .i_DrawX(DrawX), .i_DrawY(DrawY),
        .i_frame_start(frame_start), .i_is_shape(is_shape), .i_is_boundary(is_boundary),
        .o_cell_row(cell_row), .o_cell_col(cell_col), .i_cell_code(cell_code),
        .i_clear_start(clear_start), .i_clear_mask(clear_mask),
        .o_busy(busy), .o_clear_done(clear_done), .o_is_background(is_background),
        .o_backRed(backRed), .o_backGreen(backGreen), .o_backBlue(backBlue));

    field_renderer #(.ROWS(16), .COLS(8), .CELL(16), .ORIGIN_X(64)) dut2 (
        .i_Clk(Clk), .i_Reset(Reset), .i_DrawX(DrawX2), .i_DrawY(DrawY2),
        .i_frame_start(1'b0), .i_is_shape(1'b0), .i_is_boundary(1'b0),
        .o_cell_row(cell_row2), .o_cell_col(cell_col2), .i_cell_code(7'd0),
        .i_clear_start(1'b0), .i_clear_mask(16'd0),
        .o_busy(busy2), .o_clear_done(done2), .o_is_background(bg2),
        .o_backRed(r2), .o_backGreen(g2), .o_backBlue(b2));

    // field memory: synchronous read, data one cycle after the address
    logic [6:0] mem [ROWS][COLS];
    always @(posedge Clk) cell_code <= mem[cell_row][cell_col];

    typedef struct packed {
        logic        bg;
        logic [23:0] rgb;
        logic [9:0]  x;
        logic [9:0]  y;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    logic issue = 1'b0;
    logic [1:0] pv = 2'b00;
    logic [ROWS-1:0] m_mask = '0;

    always @(posedge Clk) pv <= {pv[0], issue};
    always @(negedge Clk) if (clear_done === 1'b1) done_cnt++;

    // monitor: pixel result is due two edges after it was presented
    always @(negedge Clk) begin
        if (pv[1]) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL pixel_queue_empty got=output want=expectation");
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({is_background, backRed, backGreen, backBlue} !== {e.bg, e.rgb}) begin
                    bad++;
                    $display("FAIL pix(%0d,%0d) got bg=%0b rgb=%06h want bg=%0b rgb=%06h",
                             e.x, e.y, is_background, {backRed, backGreen, backBlue}, e.bg, e.rgb);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic logic [23:0] palette(input int code, input bit edge_px);
        case (code)
            0: return edge_px ? 24'h404040 : 24'h000000;
            1: return 24'h00FFFF;
            2: return 24'hFFFF00;
            3: return 24'h800080;
            4: return 24'h00FF00;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            7: return 24'hFFA500;
            default: return 24'h808080;
        endcase
    endfunction

    // flash: 0 = no sequence running, 1 = on phase, 2 = off phase
    function automatic exp_t model(input int x, input int y, input bit sh, input bit bn, input int flash);
        exp_t e;
        bit field, wall;
        int r, c;
        e.x = 10'(x);
        e.y = 10'(y);
        field = (x >= OX) && (x < OX + COLS*CELL) && (y < ROWS*CELL);
        wall  = (y < ROWS*CELL) && ((x >= OX-10 && x < OX) || (x >= OX + COLS*CELL && x < OX + COLS*CELL + 10));
        e.bg  = 1'b0;
        e.rgb = 24'hFFFFFF;
        if (wall) begin
            e.bg  = 1'b1;
            e.rgb = 24'h87CEEB;
        end else if (field && !sh && !bn) begin
            r = y / CELL;
            c = (x - OX) / CELL;
            e.bg = 1'b1;
            if (flash != 0 && m_mask[r])
                e.rgb = (flash == 1) ? 24'hFFFFFF : 24'h000000;
            else
                e.rgb = palette(int'(mem[r][c]), ((x - OX) % CELL == 0) || (y % CELL == 0));
        end
        return e;
    endfunction

    task automatic pix(input int x, input int y, input bit sh, input bit bn, input int flash);
        bit field;
        @(negedge Clk);
        DrawX = 10'(x); DrawY = 10'(y); is_shape = sh; is_boundary = bn;
        issue = 1'b1;
        q.push_back(model(x, y, sh, bn, flash));
        field = (x >= OX) && (x < OX + COLS*CELL) && (y < ROWS*CELL);
        #1;
        chk("cell_row", 32'(cell_row), field ? 32'(y / CELL) : 32'd0);
        chk("cell_col", 32'(cell_col), field ? 32'((x - OX) / CELL) : 32'd0);
    endtask

    task automatic idle(input int n);
        @(negedge Clk);
        issue = 1'b0;
        repeat (n - 1) @(negedge Clk);
    endtask

    task automatic frame();
        @(negedge Clk);
        issue = 1'b0;
        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
    endtask

    task automatic clear(input logic [ROWS-1:0] m, input bit with_frame);
        @(negedge Clk);
        issue = 1'b0;
        clear_start = 1'b1;
        clear_mask = m;
        frame_start = with_frame;
        @(negedge Clk);
        clear_start = 1'b0;
        clear_mask = '0;
        frame_start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int ph;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mem[r][c] = ($urandom_range(0, 9) < 8) ? 7'($urandom_range(0, 7)) : 7'($urandom_range(8, 127));

        // reset state
        repeat (3) @(negedge Clk);
        chk("rst_bg",   32'(is_background), 32'd0);
        chk("rst_rgb",  32'({backRed, backGreen, backBlue}), 32'hFFFFFF);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(clear_done), 32'd0);
        Reset = 1'b0;

        // directed pixels
        mem[0][0] = 7'd5;
        mem[1][1] = 7'd0;
        pix(200, 0, 0, 0, 0);
        pix(195, 100, 0, 0, 0);
        pix(445, 100, 0, 0, 0);
        pix(100, 100, 0, 0, 0);
        pix(247, 47, 1, 0, 0);
        pix(247, 47, 0, 0, 0);
        pix(224, 24, 0, 0, 0);
        pix(189, 100, 0, 0, 0);
        pix(450, 100, 0, 0, 0);
        pix(439, 479, 0, 0, 0);
        pix(300, 480, 0, 0, 0);
        pix(300, 200, 0, 1, 0);

        // random pixels, biased toward the field and walls
        for (int i = 0; i < 300; i++) begin
            int x;
            x = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 639) : $urandom_range(185, 455);
            pix(x, $urandom_range(0, 524), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), 0);
        end
        idle(4);

        // flash of row 19; the frame pulse coinciding with clear_start is not counted
        m_mask = '0;
        m_mask[19] = 1'b1;
        mem[0][3] = 7'd2;
        clear(m_mask, 1'b1);
        idle(2);
        chk("busy_start", 32'(busy), 32'd1);
        pix(OX + 5*CELL + 3, 19*CELL + 5, 0, 0, 1);
        idle(4);
        for (int k = 1; k <= NPF; k++) begin
            frame();
            if (k == 3) clear(20'h00001, 1'b0);
            if (k < NPF) begin
                ph = ((k / FF) % 2 == 0) ? 1 : 2;
                idle(2);
                pix(OX + 5*CELL + 3, 19*CELL + 5, 0, 0, ph);
                pix(OX + 3*CELL + 7, 9, 0, 0, ph);
                idle(4);
                chk("busy_flash", 32'(busy), 32'd1);
                chk("no_early_done", 32'(done_cnt), 32'd0);
            end
        end
        chk("done_pulse_now", 32'(clear_done), 32'd1);
        idle(4);
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
        m_mask = '0;
        pix(OX + 5*CELL + 3, 19*CELL + 5, 0, 0, 0);
        idle(4);

        // reset mid-flash aborts without a completion pulse
        m_mask = '0;
        m_mask[3] = 1'b1;
        clear(m_mask, 1'b0);
        for (int k = 0; k < 10; k++) frame();
        idle(3);
        chk("busy_before_abort", 32'(busy), 32'd1);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("busy_abort", 32'(busy), 32'd0);
        idle(6);
        chk("abort_no_done", 32'(done_cnt), 32'd1);
        m_mask = '0;
        pix(OX + 2*CELL + 4, 3*CELL + 4, 0, 0, 0);
        idle(4);

        // reduced parameter set
        @(negedge Clk);
        DrawX2 = 10'd176; DrawY2 = 10'd240;
        #1;
        chk("p2_row", 32'(cell_row2), 32'd15);
        chk("p2_col", 32'(cell_col2), 32'd7);
        @(negedge Clk);
        DrawX2 = 10'd192; DrawY2 = 10'd100;
        @(negedge Clk);
        DrawX2 = 10'd191; DrawY2 = 10'd100;
        chk("p2_grid", 32'({bg2, r2, g2, b2}), {7'd0, 1'b1, 24'h404040});
        @(negedge Clk);
        chk("p2_wall", 32'({bg2, r2, g2, b2}), {7'd0, 1'b1, 24'h87CEEB});
        @(negedge Clk);
        chk("p2_last_col", 32'({bg2, r2, g2, b2}), {7'd0, 1'b1, 24'h000000});

        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL queue_drain got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/field_renderer.md
FIELD_RENDERER -- requirements
Module: field_renderer

Interface
REQ-001 Parameter ROWS, default 20, playfield rows.
REQ-002 Parameter COLS, default 10, playfield columns.
REQ-003 Parameter CELL, default 24, cell edge in pixels.
REQ-004 Parameter ORIGIN_X / ORIGIN_Y, default 200 / 0, top-left pixel of cell (0,0).
REQ-005 Parameter WALL_W, default 10, side-wall width in pixels.
REQ-006 Parameter FLASH_FRAMES, default 8, frames per flash phase; FLASH_PAIRS, default 3, on/off pairs per clear.
REQ-007 Parameter GRID_EN, default 1, draws grid lines on empty cells when 1.
REQ-008 Clk  input  1  single clock for all state.
REQ-009 Reset  input  1  synchronous, active-high reset.
REQ-010 DrawX, DrawY  input  10 each  current pixel coordinate.
REQ-011 frame_start  input  1  one-cycle pulse per frame.
REQ-012 is_shape, is_boundary  input  1 each  falling piece / boundary owns pixel, aligned with DrawX/DrawY.
REQ-013 cell_row  output  $clog2(ROWS); cell_col  output  $clog2(COLS)  combinational field-memory read address.
REQ-014 cell_code  input  7  field memory data, valid one cycle after the address.
REQ-015 clear_start  input  1  pulse requesting a line-clear flash; clear_mask  input  ROWS  rows to flash.
REQ-016 busy  output  1  flash sequence in progress; clear_done  output  1  one-cycle completion pulse.
REQ-017 is_background  output  1; backRed, backGreen, backBlue  output  8 each  registered pixel result.

Function
REQ-018 Field region: ORIGIN_X <= DrawX < ORIGIN_X+COLS*CELL and ORIGIN_Y <= DrawY < ORIGIN_Y+ROWS*CELL; all compares at least 11 bits wide, with no unsigned-subtract compares.
REQ-019 Wall region: same Y span; X in [ORIGIN_X-WALL_W, ORIGIN_X) or [ORIGIN_X+COLS*CELL, +WALL_W).
REQ-020 Stage 0 (comb): cell_row=(DrawY-ORIGIN_Y)/CELL, cell_col=(DrawX-ORIGIN_X)/CELL inside the field, else 0; also compute sub-cell offsets and region flags.
REQ-021 Stage 1 register: region flags, is_shape/is_boundary, row index, grid-edge flag (sub-offset X or Y == 0); cell_code arrives here.
REQ-022 Stage 2 register: outputs; total latency DrawX/DrawY to outputs is 2 Clk cycles.
REQ-023 Priority 1, wall: is_background=1, RGB=87,CE,EB.
REQ-024 Priority 2, field pixel with is_shape=0 and is_boundary=0: is_background=1, with colour from REQ-025 to REQ-027.
REQ-025 Flashing row (busy, latched mask bit set): FLASH_ON gives FF,FF,FF; FLASH_OFF gives 00,00,00.
REQ-026 Otherwise use the palette on cell_code: 0 = 00,00,00 (or 40,40,40 on grid edge if GRID_EN); 1 = 00,FF,FF; 2 = FF,FF,00; 3 = 80,00,80; 4 = 00,FF,00; 5 = FF,00,00; 6 = 00,00,FF; 7 = FF,A5,00; 8-127 = 80,80,80.
REQ-027 Any other pixel: is_background=0, RGB=FF,FF,FF.
REQ-028 FSM states are IDLE, FLASH_ON, FLASH_OFF, DONE.
REQ-029 IDLE: clear_start=1 with nonzero clear_mask latches the mask, clears the frame and pair counters, and moves to FLASH_ON; a zero mask is ignored.
REQ-030 FLASH_ON: count frame_start pulses; the FLASH_FRAMES-th pulse moves to FLASH_OFF with the counter cleared.
REQ-031 FLASH_OFF: the FLASH_FRAMES-th pulse increments the pair count; the FSM goes to DONE if pairs==FLASH_PAIRS, else to FLASH_ON.
REQ-032 DONE: clear_done=1 for exactly one cycle, then IDLE.
REQ-033 busy=1 in FLASH_ON, FLASH_OFF and DONE.
REQ-034 clear_start while busy is ignored, and the latched mask is unchanged.
REQ-035 clear_start and frame_start in the same IDLE cycle: the frame pulse is not counted.

Reset
REQ-036 On Reset=1 at a Clk edge: FSM=IDLE; counters, latched mask, pipeline flags and is_background become 0; RGB becomes FF,FF,FF; busy=0; clear_done=0.
REQ-037 Reset mid-flash aborts the sequence without a clear_done pulse.

Verification
REQ-038 Pixel (200,0), cell_code=5, no shape -> two cycles later is_background=1, RGB=FF,00,00; cell_row=0, cell_col=0.
REQ-039 Pixel (195,100) -> 87,CE,EB; pixel (445,100) -> 87,CE,EB; pixel (100,100) -> is_background=0, FF,FF,FF.
REQ-040 Pixel (247,47), is_shape=1 -> is_background=0; same pixel with is_shape=0 and code 0 -> 00,00,00; pixel (224,24) with code 0 -> 40,40,40.
REQ-041 clear_mask bit 19 set, clear_start pulse, then 48 frame_start pulses -> row 19 shows FF/00 alternating every 8 frames; clear_done pulses once after the 48th pulse; busy stays 1 until then.
REQ-042 Second clear_start during flash -> ignored; Reset after 10 frames -> busy=0 next cycle, no clear_done.
REQ-043 Parameter set ROWS=16, COLS=8, CELL=16, ORIGIN_X=64 -> pixel (64+7*16, 15*16) maps to cell (15,7); x=64+128 is the right wall.
